core_array_sequencer: RTL and testbench
=======================================

Name: core_array_sequencer

Overview:
- Parametrised successor to the single-core top-level. Launches and supervises NUM_CORES identical processor cores.
- Assigns each core its coreID and holds cores in reset. Gates the shared scaled-clock enable.
- Collects each core's end_process, counts per-core execution cycles and runs a global watchdog.
- Sits between the host/testbench start logic and the core array; replaces the hand-driven clock_en/controlRST/coreID pins of one core.

Parameters:
- NUM_CORES, 4: number of cores supervised (1..16).
- ID_WIDTH, 16: width of each coreID.
- ID_BASE, 0: coreID of core 0; core i receives ID_BASE+i.
- CNT_WIDTH, 24: width of per-core cycle counters and the watchdog.
- RST_CYCLES, 2: cycles core_rst is held for all cores before RUN (>=1).
- TIMEOUT, 100000: RUN cycles allowed before error (>=1, < 2^CNT_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE/DONE/ERR to begin a run.
- core_en_mask  in  NUM_CORES  cores taking part in the run; latched at start.
- core_endp  in  NUM_CORES  end_process from each core.
- sel_core  in  4  index for cycle_count readout.
- core_id  out  NUM_CORES*ID_WIDTH  flat bus; slice i = ID_BASE+i, constant.
- core_rst  out  NUM_CORES  per-core controlRST.
- clock_en  out  1  enable to the shared scaled clock.
- busy  out  1  high in RST_CORES and RUN.
- done  out  1  high in DONE.
- timeout_err  out  1  high in ERR.
- finished_mask  out  NUM_CORES  cores that have reported endp this run.
- cycle_count  out  CNT_WIDTH  counter of core sel_core, combinational.

Behaviour:
- Outputs are registered except cycle_count and core_id.
- FSM states: IDLE, RST_CORES, RUN, DONE, ERR.
- On rst (any state, mid-run included), next cycle:
  - state=IDLE, core_rst all 1, clock_en=0, busy=done=timeout_err=0.
  - finished_mask=0, all counters and watchdog=0, active_mask=0.
- IDLE/DONE/ERR accepting start=1:
  - Latch active_mask=core_en_mask; clear counters, watchdog and finished_mask; clear done and timeout_err.
  - Mask zero: go to DONE directly (done=1 next cycle).
  - Mask nonzero: go to RST_CORES with rst_cnt=RST_CYCLES-1.
  - start is level-sensitive. If start is still high in DONE/ERR, a new run begins; the host deasserts start after observing busy.
- RST_CORES:
  - core_rst all 1, clock_en=1, busy=1.
  - Decrement rst_cnt each cycle; at 0 go to RUN. Dwell is exactly RST_CYCLES cycles.
- RUN:
  - clock_en=1, busy=1. core_rst[i]=0 if active_mask[i], else 1.
  - Watchdog increments each cycle.
  - For each active core with finished_mask[i]=0: cnt[i]+=1 this cycle (including the cycle core_endp[i] is seen).
  - If core_endp[i]=1, set finished_mask[i]=1; cnt[i] then freezes.
  - core_endp of inactive or already-finished cores is ignored.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - Exit when (finished_mask | (core_endp & active_mask)) == active_mask: go to DONE.
  - Else, if watchdog == TIMEOUT-1: go to ERR.
  - If the last endp and the timeout fall in the same cycle, DONE wins.
- DONE:
  - clock_en=0 (cores freeze, state retained for readout), core_rst unchanged from RUN.
  - done=1, busy=0.
- ERR:
  - clock_en=0, core_rst all 1, timeout_err=1, busy=0.
  - finished_mask and counters hold for diagnosis.
- start while busy is ignored.
- sel_core >= NUM_CORES gives cycle_count=0.
- Run latency (nonzero mask): busy rises 1 cycle after start is sampled. done rises 1 cycle after the final endp cycle.

Test Plan:
- Reset then idle (NUM_CORES=4, ID_BASE=0x10): after rst, core_rst=4'b1111, clock_en=0, core_id slices 0x10,0x11,0x12,0x13; holds with start=0.
- Full run, mask 4'b1111: endp of cores 0..3 at RUN cycles 5,9,9,20 → cycle_count 5,9,9,20. finished_mask tracks each endp. done=1 one cycle after cycle 20; clock_en=0 in DONE.
- Partial mask 4'b0101: core_rst=4'b1010 in RUN. endp pulses on cores 1 and 3 are ignored. DONE after cores 0 and 2 finish; cycle_count(1)=0.
- Timeout (TIMEOUT=50): core 2 never asserts endp → ERR after RUN cycle 50 with timeout_err=1, core_rst=4'b1111, finished_mask=4'b1011. Variant with last endp on cycle 50 → DONE.
- Reset mid-run at RUN cycle 7 → IDLE next cycle, all counters 0, core_rst=4'b1111. start during RUN → no restart, counts unaffected.
- Zero mask: start with mask 0 → done=1 next cycle, busy never asserted. Saturation (CNT_WIDTH=4, TIMEOUT=15): a core finishing at cycle 15 reads cycle_count=15 (0xF) and does not wrap.

Source files
------------

// File: rtl/core_array_sequencer.sv
// Launch-and-supervise sequencer for an array of identical cores: hands out coreIDs,
// sequences per-core reset, gates the shared scaled clock, counts per-core cycles, runs a watchdog.
module core_array_sequencer #(
    parameter int NUM_CORES  = 4,
    parameter int ID_WIDTH   = 16,
    parameter int ID_BASE    = 0,
    parameter int CNT_WIDTH  = 24,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CORES-1:0]          core_en_mask,
    input  logic [NUM_CORES-1:0]          core_endp,
    input  logic [3:0]                    sel_core,
    output logic [NUM_CORES*ID_WIDTH-1:0] core_id,
    output logic [NUM_CORES-1:0]          core_rst,
    output logic                          clock_en,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [NUM_CORES-1:0]          finished_mask,
    output logic [CNT_WIDTH-1:0]          cycle_count
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_CORES = 3'd1,
        S_RUN       = 3'd2,
        S_DONE      = 3'd3,
        S_ERR       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   active_q, active_d;
    logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0]   wdog_q, wdog_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_CORES];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_CORES];
    logic [NUM_CORES-1:0]   fin_d;
    logic [NUM_CORES-1:0]   core_rst_d;
    logic                   clock_en_d, busy_d, done_d, err_d;
    logic                   all_done;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_id
        assign core_id[g*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(ID_BASE + g);
    end

    assign all_done = ((finished_mask | (core_endp & active_q)) == active_q);

    // Start handshake: start is a level sampled only while not busy; the host holds it
    // until it sees busy (or done for an empty mask) and must drop it before the run ends.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        rst_cnt_d  = rst_cnt_q;
        wdog_d     = wdog_q;
        cnt_d      = cnt_q;
        fin_d      = finished_mask;
        core_rst_d = core_rst;
        clock_en_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = done;
        err_d      = timeout_err;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    active_d   = core_en_mask;
                    wdog_d     = '0;
                    fin_d      = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    core_rst_d = '1;
                    for (int i = 0; i < NUM_CORES; i++) cnt_d[i] = '0;
                    if (core_en_mask == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_RST_CORES;
                        rst_cnt_d  = RCW'(RST_CYCLES - 1);
                        clock_en_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_RST_CORES: begin
                clock_en_d = 1'b1;
                busy_d     = 1'b1;
                if (rst_cnt_q == '0) begin
                    state_d    = S_RUN;
                    core_rst_d = ~active_q;
                end else begin
                    rst_cnt_d  = rst_cnt_q - RCW'(1);
                    core_rst_d = '1;
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + CNT_WIDTH'(1);
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (active_q[i] && !finished_mask[i]) begin
                        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                        if (core_endp[i]) fin_d[i] = 1'b1;
                    end
                end
                // A core finishing on the watchdog's last cycle still counts as a clean finish.
                if (all_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    core_rst_d = '1;
                end else begin
                    clock_en_d = 1'b1;
                    busy_d     = 1'b1;
                    core_rst_d = ~active_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                core_rst_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            active_q      <= '0;
            rst_cnt_q     <= '0;
            wdog_q        <= '0;
            for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
            finished_mask <= '0;
            core_rst      <= '1;
            clock_en      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            rst_cnt_q     <= rst_cnt_d;
            wdog_q        <= wdog_d;
            cnt_q         <= cnt_d;
            finished_mask <= fin_d;
            core_rst      <= core_rst_d;
            clock_en      <= clock_en_d;
            busy          <= busy_d;
            done          <= done_d;
            timeout_err   <= err_d;
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        cycle_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_core == 4'(i)) cycle_count = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_core_array_sequencer.sv
// Directed bench for core_array_sequencer: one main instance (TIMEOUT=50, ID_BASE=0x10)
// and a narrow-counter instance (CNT_WIDTH=4, TIMEOUT=15, RST_CYCLES=1) for the saturation boundary.
module tb_core_array_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start;
    logic [3:0]  core_en_mask, core_endp, sel_core;
    logic [63:0] core_id;
    logic [3:0]  core_rst, finished_mask;
    logic        clock_en, busy, done, timeout_err;
    logic [23:0] cycle_count;

    logic        s_start;
    logic [3:0]  s_mask, s_endp, s_sel;
    logic [63:0] s_core_id;
    logic [3:0]  s_core_rst, s_finished;
    logic        s_clock_en, s_busy, s_done, s_err;
    logic [3:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v;

    core_array_sequencer #(.NUM_CORES(4), .ID_WIDTH(16), .ID_BASE(16), .CNT_WIDTH(24),
                           .RST_CYCLES(2), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .start(start), .core_en_mask(core_en_mask),
        .core_endp(core_endp), .sel_core(sel_core), .core_id(core_id),
        .core_rst(core_rst), .clock_en(clock_en), .busy(busy), .done(done),
        .timeout_err(timeout_err), .finished_mask(finished_mask), .cycle_count(cycle_count)
    );

    core_array_sequencer #(.NUM_CORES(4), .ID_WIDTH(16), .ID_BASE(0), .CNT_WIDTH(4),
                           .RST_CYCLES(1), .TIMEOUT(15)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .core_en_mask(s_mask),
        .core_endp(s_endp), .sel_core(s_sel), .core_id(s_core_id),
        .core_rst(s_core_rst), .clock_en(s_clock_en), .busy(s_busy), .done(s_done),
        .timeout_err(s_err), .finished_mask(s_finished), .cycle_count(s_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and advance to RUN cycle 1; reports busy/err right after start is sampled.
    task automatic launch(input logic [3:0] m, output logic busy_seen, output logic err_seen,
                          output logic [3:0] rst_seen);
        start = 1'b1;
        core_en_mask = m;
        tick();
        busy_seen = busy;
        err_seen = timeout_err;
        start = 1'b0;
        tick();
        tick();
        rst_seen = core_rst;
    endtask

    // Drive core i's endp in RUN cycle e_i (0 = never); optional start pulse at start_at.
    task automatic run_to_end(input int e0, input int e1, input int e2, input int e3,
                              input int budget, input int start_at, output int last);
        last = 0;
        for (int k = 1; k <= budget; k++) begin
            core_endp[0] = (k == e0);
            core_endp[1] = (k == e1);
            core_endp[2] = (k == e2);
            core_endp[3] = (k == e3);
            start = (start_at != 0) && (k == start_at || k == start_at + 1);
            if (start) core_en_mask = 4'b0001;
            tick();
            core_endp = '0;
            start = 1'b0;
            if (done || timeout_err) begin
                last = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sel_core = 4'd0;
        #1;
        n_checks++; if (core_rst !== 4'b1111) begin n_fail++; $display("FAIL reset_core_rst: got %b expected 1111", core_rst); end
        n_checks++; if (clock_en !== 1'b0) begin n_fail++; $display("FAIL reset_clock_en: got %b expected 0", clock_en); end
        n_checks++; if ({busy, done, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, timeout_err}); end
        n_checks++; if (finished_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_finished: got %b expected 0000", finished_mask); end
        n_checks++; if (core_id !== 64'h0013_0012_0011_0010) begin n_fail++; $display("FAIL reset_core_id: got %h expected 0013001200110010", core_id); end
        n_checks++; if (cycle_count !== 24'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
        tick();
        tick();
        tick();
        n_checks++; if (core_rst !== 4'b1111 || busy !== 1'b0 || clock_en !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got rst=%b busy=%b ce=%b expected 1111/0/0", core_rst, busy, clock_en); end
    endtask

    task automatic test_full_run();
        logic b, e;
        logic [3:0] r;
        int last;
        launch(4'b1111, b, e, r);
        n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", b); end
        n_checks++; if (r !== 4'b0000) begin n_fail++; $display("FAIL full_core_rst: got %b expected 0000", r); end
        n_checks++; if (clock_en !== 1'b1) begin n_fail++; $display("FAIL full_clock_en_run: got %b expected 1", clock_en); end
        run_to_end(5, 9, 9, 20, 60, 0, last);
        n_checks++; if (last !== 20) begin n_fail++; $display("FAIL full_length: got %0d expected 20", last); end
        n_checks++; if ({done, busy, clock_en} !== 3'b100) begin n_fail++; $display("FAIL full_done_flags: got %b expected 100", {done, busy, clock_en}); end
        n_checks++; if (finished_mask !== 4'b1111) begin n_fail++; $display("FAIL full_finished: got %b expected 1111", finished_mask); end
        exp_q = '{24'd5, 24'd9, 24'd9, 24'd20};
        for (int i = 0; i < 4; i++) begin
            sel_core = 4'(i);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++; if (cycle_count !== exp_v) begin n_fail++; $display("FAIL full_count%0d: got %0d expected %0d", i, cycle_count, exp_v); end
        end
        sel_core = 4'd7;
        #1;
        n_checks++; if (cycle_count !== 24'd0) begin n_fail++; $display("FAIL sel_out_of_range: got %0d expected 0", cycle_count); end
    endtask

    task automatic test_partial_mask();
        logic b, e;
        logic [3:0] r;
        int last;
        launch(4'b0101, b, e, r);
        n_checks++; if (r !== 4'b1010) begin n_fail++; $display("FAIL partial_core_rst: got %b expected 1010", r); end
        run_to_end(4, 2, 7, 3, 60, 0, last);
        n_checks++; if (last !== 7 || done !== 1'b1) begin n_fail++; $display("FAIL partial_length: got %0d done=%b expected 7 done=1", last, done); end
        n_checks++; if (finished_mask !== 4'b0101) begin n_fail++; $display("FAIL partial_finished: got %b expected 0101", finished_mask); end
        n_checks++; if (core_rst !== 4'b1010) begin n_fail++; $display("FAIL partial_done_core_rst: got %b expected 1010", core_rst); end
        exp_q = '{24'd4, 24'd0, 24'd7, 24'd0};
        for (int i = 0; i < 4; i++) begin
            sel_core = 4'(i);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++; if (cycle_count !== exp_v) begin n_fail++; $display("FAIL partial_count%0d: got %0d expected %0d", i, cycle_count, exp_v); end
        end
    endtask

    task automatic test_timeout();
        logic b, e;
        logic [3:0] r;
        int last;
        launch(4'b1111, b, e, r);
        run_to_end(3, 10, 0, 30, 70, 0, last);
        n_checks++; if (last !== 50) begin n_fail++; $display("FAIL timeout_length: got %0d expected 50", last); end
        n_checks++; if ({timeout_err, done, busy, clock_en} !== 4'b1000) begin n_fail++; $display("FAIL timeout_flags: got %b expected 1000", {timeout_err, done, busy, clock_en}); end
        n_checks++; if (core_rst !== 4'b1111) begin n_fail++; $display("FAIL timeout_core_rst: got %b expected 1111", core_rst); end
        n_checks++; if (finished_mask !== 4'b1011) begin n_fail++; $display("FAIL timeout_finished: got %b expected 1011", finished_mask); end
        exp_q = '{24'd3, 24'd10, 24'd50, 24'd30};
        for (int i = 0; i < 4; i++) begin
            sel_core = 4'(i);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++; if (cycle_count !== exp_v) begin n_fail++; $display("FAIL timeout_count%0d: got %0d expected %0d", i, cycle_count, exp_v); end
        end
        // Restart from ERR; last endp lands on the watchdog's final cycle.
        launch(4'b1111, b, e, r);
        n_checks++; if (b !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL restart_from_err: got busy=%b err=%b expected 1/0", b, e); end
        run_to_end(3, 10, 50, 30, 70, 0, last);
        n_checks++; if (last !== 50 || done !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL tie_done_wins: got len=%0d done=%b err=%b expected 50/1/0", last, done, timeout_err); end
        sel_core = 4'd2;
        #1;
        n_checks++; if (cycle_count !== 24'd50) begin n_fail++; $display("FAIL tie_count2: got %0d expected 50", cycle_count); end
    endtask

    task automatic test_start_during_run();
        logic b, e;
        logic [3:0] r;
        int last;
        launch(4'b1111, b, e, r);
        run_to_end(2, 4, 6, 8, 60, 3, last);
        n_checks++; if (last !== 8 || done !== 1'b1) begin n_fail++; $display("FAIL busy_start_length: got %0d done=%b expected 8 done=1", last, done); end
        n_checks++; if (finished_mask !== 4'b1111) begin n_fail++; $display("FAIL busy_start_finished: got %b expected 1111", finished_mask); end
        exp_q = '{24'd2, 24'd4, 24'd6, 24'd8};
        for (int i = 0; i < 4; i++) begin
            sel_core = 4'(i);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++; if (cycle_count !== exp_v) begin n_fail++; $display("FAIL busy_start_count%0d: got %0d expected %0d", i, cycle_count, exp_v); end
        end
    endtask

    task automatic test_midrun_reset();
        logic b, e;
        logic [3:0] r;
        int last;
        launch(4'b1111, b, e, r);
        run_to_end(3, 0, 0, 0, 6, 0, last);
        n_checks++; if (last !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL midrun_pre: got len=%0d busy=%b expected 0/1", last, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sel_core = 4'd0;
        #1;
        n_checks++; if ({busy, done, timeout_err, clock_en} !== 4'b0000) begin n_fail++; $display("FAIL midrun_flags: got %b expected 0000", {busy, done, timeout_err, clock_en}); end
        n_checks++; if (core_rst !== 4'b1111) begin n_fail++; $display("FAIL midrun_core_rst: got %b expected 1111", core_rst); end
        n_checks++; if (finished_mask !== 4'b0000 || cycle_count !== 24'd0) begin n_fail++; $display("FAIL midrun_clear: got fin=%b cnt0=%0d expected 0000/0", finished_mask, cycle_count); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_zero_mask();
        start = 1'b1;
        core_en_mask = 4'b0000;
        tick();
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_mask_done: got done=%b busy=%b expected 1/0", done, busy); end
        tick();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || clock_en !== 1'b0) begin n_fail++; $display("FAIL zero_mask_hold: got done=%b busy=%b ce=%b expected 1/0/0", done, busy, clock_en); end
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        s_mask = 4'b0001;
        tick();
        s_start = 1'b0;
        n_checks++; if (s_busy !== 1'b1 || s_core_rst !== 4'b1111 || s_clock_en !== 1'b1) begin n_fail++; $display("FAIL sat_rst_phase: got busy=%b rst=%b ce=%b expected 1/1111/1", s_busy, s_core_rst, s_clock_en); end
        tick();
        n_checks++; if (s_core_rst !== 4'b1110) begin n_fail++; $display("FAIL sat_run_core_rst: got %b expected 1110", s_core_rst); end
        for (int k = 1; k <= 15; k++) begin
            s_endp[0] = (k == 15);
            tick();
            s_endp = '0;
        end
        s_sel = 4'd0;
        #1;
        n_checks++; if (s_done !== 1'b1 || s_err !== 1'b0) begin n_fail++; $display("FAIL sat_done: got done=%b err=%b expected 1/0", s_done, s_err); end
        n_checks++; if (s_count !== 4'hF) begin n_fail++; $display("FAIL sat_count: got %h expected f", s_count); end
        n_checks++; if (s_core_id[63:48] !== 16'h0003) begin n_fail++; $display("FAIL sat_core_id3: got %h expected 0003", s_core_id[63:48]); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit reached");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        core_en_mask = '0;
        core_endp = '0;
        sel_core = '0;
        s_start = 1'b0;
        s_mask = '0;
        s_endp = '0;
        s_sel = '0;
        test_reset();
        test_full_run();
        test_partial_mask();
        test_timeout();
        test_start_during_run();
        test_midrun_reset();
        test_zero_mask();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
